core_buf: RTL and testbench
===========================

# core_buf

Tile buffer for the rotation core. It sits between the DMA read-data path and the DMA write-data path, alongside the set address generator. It captures one 8x8 pixel set (64 RGB pixels, 24 bits each) in raster order while the address generator is in its read phase. During the write phase it replays the set in rotated order, so each write address issued by the address generator is paired with the correctly re-indexed pixel.

## Interface
Parameters:
- PIX_W, 24, pixel width in bits (3 bytes, RGB)
- SET_DIM, 8, tile edge; the set holds SET_DIM*SET_DIM = 64 pixels

Ports:
- I_HCLK  in  1  clock, rising edge
- I_HRESET_N  in  1  reset, asynchronous, active-low
- I_START  in  1  pulse; in IDLE, latches rotation config and enters FILL
- I_CLEAR  in  1  synchronous abort; returns to IDLE from any state
- I_DIRECTION  in  1  1 = clockwise, 0 = counter-clockwise
- I_DEGREES  in  2  0/1/2/3 = 0/90/180/270 degrees
- I_WRITE  in  1  phase from address generator: 0 = read beats (load), 1 = write beats (drain)
- I_DMA_READY  in  1  beat strobe; one pixel transferred per cycle it is high
- I_DATA  in  PIX_W  pixel from DMA read data
- O_DATA  out  PIX_W  rotated pixel for the current drain beat
- O_VALID  out  1  O_DATA is meaningful (state FULL or DRAIN)
- O_COUNT  out  7  occupancy, 0..64
- O_FULL  out  1  O_COUNT == 64
- O_EMPTY  out  1  O_COUNT == 0
- O_ERR  out  1  sticky protocol error flag

## Operation
- Storage: 64 x PIX_W flop array mem, written in raster order, so load index i = 8*r + c.
- Config latch: on I_START in IDLE, compute eff = I_DIRECTION ? I_DEGREES : (4 - I_DEGREES) mod 4 and store it in a 2-bit register. The config inputs are ignored at all other times.
- States:
  - IDLE: counters are 0. Exits to FILL on I_START.
  - FILL: each load beat (I_DMA_READY && !I_WRITE) writes mem[fill_cnt] <= I_DATA and increments fill_cnt. On the 64th beat, go to FULL and reset fill_cnt to 0.
  - FULL: the first drain beat (I_DMA_READY && I_WRITE) moves to DRAIN with drain_cnt = 1.
  - DRAIN: each drain beat increments drain_cnt. On the 64th drain beat, go to FILL for the next set; drain_cnt returns to 0.
- Drain source index: output position R = drain_cnt[5:3], C = drain_cnt[2:0]. The source (r, c) by eff:
  - 0: (R, C)
  - 1: (7-C, R)
  - 2: (7-R, 7-C)
  - 3: (C, 7-R)
- O_DATA = mem[8*r + c], combinational from drain_cnt and eff. The 7-x terms are 3-bit bitwise inversions. There is no carry.
- O_COUNT: 0 in IDLE; fill_cnt in FILL; 64 in FULL; 64 - drain_cnt in DRAIN.
- Error conditions. Each sets O_ERR, and the offending beat is ignored with no state change:
  - a drain beat in FILL;
  - a load beat in FULL or DRAIN;
  - any beat in IDLE.
- O_ERR clears only on reset or I_CLEAR.
- I_START outside IDLE is ignored, and the config is not re-latched.

## Timing
- Reset (async assert): state IDLE, all counters 0, eff 0. Outputs: O_DATA 0, O_VALID 0, O_COUNT 0, O_FULL 0, O_EMPTY 1, O_ERR 0. mem contents are not reset and are don't-care.
- Load latency: a pixel presented on a beat in cycle n is stored at edge n+1. On the cycle after the 64th load beat, O_FULL = 1 and O_DATA already shows the first rotated pixel. There is no bubble between FILL and FULL.
- Drain: O_DATA is valid during the same cycle as the drain beat that consumes it, and the next pixel appears at the following edge. Back-to-back beats sustain one pixel per cycle.
- Simultaneous events:
  - I_CLEAR has priority over all other inputs, including I_START.
  - I_START and a beat in the same IDLE cycle: enter FILL only; the beat counts as an error.
- Reset or I_CLEAR mid-FILL or mid-DRAIN discards the partial set. The next I_START begins a fresh fill at index 0.

## Structure
- Shared package core_pkg:
  - state encoding (IDLE = 2'h0, FILL = 2'h1, FULL = 2'h2, DRAIN = 2'h3);
  - degree constants DEG_0..DEG_270, identical to the address generator's values;
  - SET_PIX = 64.
- One sub-module, core_buf_map: purely combinational (eff, drain_cnt[5:0]) -> 6-bit source index. It is shared later by the write-address side to cross-check ordering.

## Test plan
- Identity: I_DIRECTION = 1, I_DEGREES = 0. Load pixels 0..63 (I_DATA = index), then drain 64 beats. O_DATA sequence must be 0, 1, ..., 63; O_COUNT goes 64 -> 0 and the block returns to FILL.
- 90 CW: I_DIRECTION = 1, I_DEGREES = 1, same load. The first drain words must be 56, 48, 40; word 8 must be 57; the last word must be 7.
- CCW 90 equals CW 270: I_DIRECTION = 0, I_DEGREES = 1. The drain sequence starts 7, 15, 23 and ends 56. Also check CW 180: the sequence starts 63 and ends 0.
- Gapped handshake: toggle I_DMA_READY at random during both fill and drain. Contents and order must match the gap-free run. O_COUNT must hold constant while I_DMA_READY is low.
- Protocol error: issue a drain beat at fill_cnt = 10. O_ERR must go to 1, fill_cnt must stay 10, and mem must be unchanged. Then I_CLEAR: O_ERR = 0, state IDLE, O_EMPTY = 1.
- Async reset asserted mid-DRAIN at drain_cnt = 30: all outputs must take their reset values immediately, without waiting for a clock edge. After release, I_START and a full new set must drain correctly.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the rotation core: buffer state encoding, rotation
// degree codes (matching the address generator), set geometry, and the
// direction/degree -> effective clockwise rotation helper.
package core_pkg;

  localparam int unsigned SET_PIX = 64;  // pixels per 8x8 set
  localparam int unsigned IDX_W   = 6;   // pixel index width
  localparam int unsigned CNT_W   = 7;   // occupancy width, 0..64

  localparam logic [1:0] DEG_0   = 2'd0;
  localparam logic [1:0] DEG_90  = 2'd1;
  localparam logic [1:0] DEG_180 = 2'd2;
  localparam logic [1:0] DEG_270 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'h0,
    ST_FILL  = 2'h1,
    ST_FULL  = 2'h2,
    ST_DRAIN = 2'h3
  } state_e;

  // Counter-clockwise rotation by d equals clockwise rotation by (4 - d) mod 4.
  function automatic logic [1:0] eff_rot(input logic dir, input logic [1:0] deg);
    return dir ? deg : 2'(~deg + 2'd1);
  endfunction

endpackage

// File: rtl/core_buf_map.sv
// Drain-order map: for output position cnt_i = {R, C} and effective
// clockwise rotation eff_i, returns the raster index {r, c} of the source
// pixel. Purely combinational.
//   eff_i        in  2  effective clockwise rotation (DEG_* codes)
//   cnt_i        in  6  output position, {R, C}
//   src_idx_c_o  out 6  source raster index, {r, c}
module core_buf_map
  import core_pkg::*;
(
  input  logic [1:0]       eff_i,
  input  logic [IDX_W-1:0] cnt_i,
  output logic [IDX_W-1:0] src_idx_c_o
);

  logic [2:0] row;
  logic [2:0] col;
  logic [2:0] src_r;
  logic [2:0] src_c;

  assign row = cnt_i[5:3];
  assign col = cnt_i[2:0];

  // 7-x is a 3-bit inversion; no carry between row and column fields.
  always_comb begin
    src_r = row;
    src_c = col;
    case (eff_i)
      DEG_0: begin
        src_r = row;
        src_c = col;
      end
      DEG_90: begin
        src_r = ~col;
        src_c = row;
      end
      DEG_180: begin
        src_r = ~row;
        src_c = ~col;
      end
      DEG_270: begin
        src_r = col;
        src_c = ~row;
      end
      default: begin
        src_r = row;
        src_c = col;
      end
    endcase
  end

  assign src_idx_c_o = {src_r, src_c};

endmodule

// File: rtl/core_buf.sv
// Tile buffer for the rotation core. Captures one 8x8 RGB set in raster
// order during the read phase and replays it in rotated order during the
// write phase.
//   I_HCLK, I_HRESET_N        clock, async active-low reset
//   I_START, I_CLEAR          start a set (IDLE only) / synchronous abort
//   I_DIRECTION, I_DEGREES    rotation config, latched on start
//   I_WRITE, I_DMA_READY      beat phase (0 load, 1 drain) and beat strobe
//   I_DATA                    load pixel
//   O_DATA, O_VALID           rotated pixel for the current drain beat
//   O_COUNT, O_FULL, O_EMPTY  occupancy 0..64 and its flags
//   O_ERR                     sticky protocol error
module core_buf
  import core_pkg::*;
#(
  parameter int unsigned PIX_W   = 24,
  parameter int unsigned SET_DIM = 8
) (
  input  logic             I_HCLK,
  input  logic             I_HRESET_N,
  input  logic             I_START,
  input  logic             I_CLEAR,
  input  logic             I_DIRECTION,
  input  logic [1:0]       I_DEGREES,
  input  logic             I_WRITE,
  input  logic             I_DMA_READY,
  input  logic [PIX_W-1:0] I_DATA,
  output logic [PIX_W-1:0] O_DATA,
  output logic             O_VALID,
  output logic [6:0]       O_COUNT,
  output logic             O_FULL,
  output logic             O_EMPTY,
  output logic             O_ERR
);

  localparam int unsigned DEPTH = SET_DIM * SET_DIM;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e           state_q,     state_d;
  logic [IDX_W-1:0] fill_cnt_q,  fill_cnt_d;
  logic [IDX_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [1:0]       eff_q,       eff_d;
  logic             err_q,       err_d;
  logic             mem_we;
  logic [PIX_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] src_idx;
  logic             load_beat;
  logic             drain_beat;

  assign load_beat  = I_DMA_READY && !I_WRITE;
  assign drain_beat = I_DMA_READY &&  I_WRITE;

  // Control state register.
  always_ff @(posedge I_HCLK or negedge I_HRESET_N) begin
    if (!I_HRESET_N) begin
      state_q     <= ST_IDLE;
      fill_cnt_q  <= '0;
      drain_cnt_q <= '0;
      eff_q       <= DEG_0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      eff_q       <= eff_d;
      err_q       <= err_d;
    end
  end

  // Pixel storage; contents are don't-care until a full set is loaded.
  always_ff @(posedge I_HCLK) begin
    if (mem_we) begin
      mem_q[fill_cnt_q] <= I_DATA;
    end
  end

  // Next-state: clear wins; an out-of-phase beat only flags the error.
  always_comb begin
    state_d     = state_q;
    fill_cnt_d  = fill_cnt_q;
    drain_cnt_d = drain_cnt_q;
    eff_d       = eff_q;
    err_d       = err_q;
    mem_we      = 1'b0;
    if (I_CLEAR) begin
      state_d     = ST_IDLE;
      fill_cnt_d  = '0;
      drain_cnt_d = '0;
      err_d       = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (I_DMA_READY) begin
            err_d = 1'b1;
          end
          if (I_START) begin
            eff_d       = eff_rot(I_DIRECTION, I_DEGREES);
            state_d     = ST_FILL;
            fill_cnt_d  = '0;
            drain_cnt_d = '0;
          end
        end
        ST_FILL: begin
          if (load_beat) begin
            mem_we = 1'b1;
            if (fill_cnt_q == LAST_IDX) begin
              state_d    = ST_FULL;
              fill_cnt_d = '0;
            end else begin
              fill_cnt_d = fill_cnt_q + IDX_W'(1);
            end
          end else if (drain_beat) begin
            err_d = 1'b1;
          end
        end
        ST_FULL: begin
          if (drain_beat) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = IDX_W'(1);
          end else if (load_beat) begin
            err_d = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (drain_beat) begin
            if (drain_cnt_q == LAST_IDX) begin
              state_d     = ST_FILL;
              drain_cnt_d = '0;
            end else begin
              drain_cnt_d = drain_cnt_q + IDX_W'(1);
            end
          end else if (load_beat) begin
            err_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  core_buf_map u_map (
    .eff_i       (eff_q),
    .cnt_i       (drain_cnt_q),
    .src_idx_c_o (src_idx)
  );

  // Outputs decode registered state only.
  assign O_VALID = (state_q == ST_FULL) || (state_q == ST_DRAIN);
  assign O_DATA  = O_VALID ? mem_q[src_idx] : '0;

  always_comb begin
    O_COUNT = '0;
    case (state_q)
      ST_IDLE:  O_COUNT = '0;
      ST_FILL:  O_COUNT = {1'b0, fill_cnt_q};
      ST_FULL:  O_COUNT = CNT_W'(DEPTH);
      ST_DRAIN: O_COUNT = CNT_W'(DEPTH) - {1'b0, drain_cnt_q};
      default:  O_COUNT = '0;
    endcase
  end

  assign O_FULL  = (O_COUNT == CNT_W'(DEPTH));
  assign O_EMPTY = (O_COUNT == '0);
  assign O_ERR   = err_q;

endmodule

// File: tb/tb_core_buf.sv
// Bench for core_buf: directed rotation sets, gapped handshakes, protocol
// error, async reset mid-drain, then random traffic against a set-level model.
module tb_core_buf;

  localparam int unsigned PIX_W = 24;
  localparam int M_IDLE  = 0;
  localparam int M_FILL  = 1;
  localparam int M_FULL  = 2;
  localparam int M_DRAIN = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             i_start, i_clear, i_direction, i_write, i_dma_ready;
  logic [1:0]       i_degrees;
  logic [PIX_W-1:0] i_data;
  logic [PIX_W-1:0] o_data;
  logic             o_valid, o_full, o_empty, o_err;
  logic [6:0]       o_count;

  always #5 clk = ~clk;

  core_buf #(.PIX_W(PIX_W), .SET_DIM(8)) dut (
    .I_HCLK      (clk),
    .I_HRESET_N  (rst_n),
    .I_START     (i_start),
    .I_CLEAR     (i_clear),
    .I_DIRECTION (i_direction),
    .I_DEGREES   (i_degrees),
    .I_WRITE     (i_write),
    .I_DMA_READY (i_dma_ready),
    .I_DATA      (i_data),
    .O_DATA      (o_data),
    .O_VALID     (o_valid),
    .O_COUNT     (o_count),
    .O_FULL      (o_full),
    .O_EMPTY     (o_empty),
    .O_ERR       (o_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Set-level reference model.
  int               m_state, m_fill, m_drain, m_eff;
  bit               m_err;
  logic [PIX_W-1:0] m_pix [64];
  logic [PIX_W-1:0] m_out [64];

  // Expected drain order: rotate the captured image 90 degrees clockwise eff times.
  task automatic build_out();
    logic [PIX_W-1:0] img [8][8];
    logic [PIX_W-1:0] tmp [8][8];
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) img[r][c] = m_pix[8*r + c];
    for (int k = 0; k < m_eff; k++) begin
      for (int r = 0; r < 8; r++)
        for (int c = 0; c < 8; c++) tmp[r][c] = img[7-c][r];
      img = tmp;
    end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) m_out[8*r + c] = img[r][c];
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_fill = 0; m_drain = 0; m_eff = 0; m_err = 1'b0;
  endtask

  task automatic model_step();
    bit ld, dr;
    ld = i_dma_ready && !i_write;
    dr = i_dma_ready &&  i_write;
    if (i_clear) begin
      m_state = M_IDLE; m_fill = 0; m_drain = 0; m_err = 1'b0;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (i_dma_ready) m_err = 1'b1;
          if (i_start) begin
            m_eff   = i_direction ? int'(i_degrees) : (4 - int'(i_degrees)) % 4;
            m_state = M_FILL; m_fill = 0; m_drain = 0;
          end
        end
        M_FILL: begin
          if (ld) begin
            m_pix[m_fill] = i_data;
            m_fill++;
            if (m_fill == 64) begin m_fill = 0; build_out(); m_state = M_FULL; end
          end else if (dr) m_err = 1'b1;
        end
        M_FULL: begin
          if (dr) begin m_drain = 1; m_state = M_DRAIN; end
          else if (ld) m_err = 1'b1;
        end
        default: begin
          if (dr) begin
            m_drain++;
            if (m_drain == 64) begin m_drain = 0; m_state = M_FILL; end
          end else if (ld) m_err = 1'b1;
        end
      endcase
    end
  endtask

  task automatic check_outputs();
    int ec;
    bit ev;
    ev = (m_state == M_FULL) || (m_state == M_DRAIN);
    case (m_state)
      M_IDLE:  ec = 0;
      M_FILL:  ec = m_fill;
      M_FULL:  ec = 64;
      default: ec = 64 - m_drain;
    endcase
    check("count", 32'(o_count), 32'(ec));
    check("full",  32'(o_full),  32'(ec == 64));
    check("empty", 32'(o_empty), 32'(ec == 0));
    check("valid", 32'(o_valid), 32'(ev));
    check("err",   32'(o_err),   32'(m_err));
    check("data",  32'(o_data),  ev ? 32'(m_out[m_drain]) : 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic idle_in();
    i_start = 1'b0; i_clear = 1'b0; i_write = 1'b0; i_dma_ready = 1'b0;
  endtask

  // Load 64 pixels then drain 64, with a gap_pct chance of an idle cycle.
  task automatic load_drain(input int gap_pct, input bit rnd_data,
                            output logic [PIX_W-1:0] got [64]);
    int beats, cyc;
    beats = 0; cyc = 0;
    while (beats < 64 && cyc < 2000) begin
      i_write = 1'b0;
      i_dma_ready = ($urandom_range(99) >= gap_pct);
      i_data = rnd_data ? PIX_W'($urandom) : PIX_W'(beats);
      if (i_dma_ready) beats++;
      step();
      cyc++;
    end
    if (beats < 64) check("load_timeout", 32'(beats), 32'd64);
    beats = 0; cyc = 0;
    while (beats < 64 && cyc < 2000) begin
      i_write = 1'b1;
      i_dma_ready = ($urandom_range(99) >= gap_pct);
      if (i_dma_ready) begin got[beats] = o_data; beats++; end
      step();
      cyc++;
    end
    if (beats < 64) check("drain_timeout", 32'(beats), 32'd64);
    idle_in();
  endtask

  task automatic run_set(input bit dir, input logic [1:0] deg, input int gap_pct,
                         input bit rnd_data, output logic [PIX_W-1:0] got [64]);
    idle_in();
    i_clear = 1'b1; step(); i_clear = 1'b0;
    i_start = 1'b1; i_direction = dir; i_degrees = deg; step(); i_start = 1'b0;
    load_drain(gap_pct, rnd_data, got);
  endtask

  logic [PIX_W-1:0] got   [64];
  logic [PIX_W-1:0] ref90 [64];

  initial begin
    rst_n = 1'b0; idle_in(); i_direction = 1'b0; i_degrees = 2'd0; i_data = '0;
    model_reset();
    for (int i = 0; i < 64; i++) begin m_pix[i] = '0; m_out[i] = '0; end
    #1;
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_empty", 32'(o_empty), 32'd1);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data",  32'(o_data),  32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Identity, then a second set without START (block returned to FILL).
    run_set(1'b1, 2'd0, 0, 1'b0, got);
    for (int i = 0; i < 64; i++) check("ident", 32'(got[i]), 32'(i));
    load_drain(0, 1'b1, got);

    // 90 CW, gap-free then gapped.
    run_set(1'b1, 2'd1, 0, 1'b0, ref90);
    check("cw90_w0",  32'(ref90[0]),  32'd56);
    check("cw90_w1",  32'(ref90[1]),  32'd48);
    check("cw90_w2",  32'(ref90[2]),  32'd40);
    check("cw90_w8",  32'(ref90[8]),  32'd57);
    check("cw90_w63", 32'(ref90[63]), 32'd7);
    run_set(1'b1, 2'd1, 40, 1'b0, got);
    for (int i = 0; i < 64; i++) check("gap_order", 32'(got[i]), 32'(ref90[i]));

    // CCW 90 == CW 270, and CW 180.
    run_set(1'b0, 2'd1, 0, 1'b0, got);
    check("ccw90_w0",  32'(got[0]),  32'd7);
    check("ccw90_w1",  32'(got[1]),  32'd15);
    check("ccw90_w2",  32'(got[2]),  32'd23);
    check("ccw90_w63", 32'(got[63]), 32'd56);
    run_set(1'b1, 2'd2, 20, 1'b0, got);
    check("cw180_w0",  32'(got[0]),  32'd63);
    check("cw180_w63", 32'(got[63]), 32'd0);

    // Drain beat at fill count 10 is flagged and ignored.
    i_clear = 1'b1; step(); i_clear = 1'b0;
    i_start = 1'b1; i_direction = 1'b1; i_degrees = 2'd0; step(); i_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      i_dma_ready = 1'b1; i_write = 1'b0; i_data = PIX_W'(100 + i); step();
    end
    i_write = 1'b1; i_data = PIX_W'(999); step();
    check("perr_err", 32'(o_err),   32'd1);
    check("perr_cnt", 32'(o_count), 32'd10);
    i_dma_ready = 1'b0;
    load_drain(0, 1'b1, got);
    for (int i = 0; i < 10; i++) check("perr_mem", 32'(got[i]), 32'(100 + i));
    i_clear = 1'b1; step(); i_clear = 1'b0;
    check("clr_err",   32'(o_err),   32'd0);
    check("clr_empty", 32'(o_empty), 32'd1);
    check("clr_valid", 32'(o_valid), 32'd0);

    // Async reset mid-drain at drain count 30.
    i_start = 1'b1; i_direction = 1'b1; i_degrees = 2'd3; step(); i_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      i_dma_ready = 1'b1; i_write = 1'b0; i_data = PIX_W'($urandom); step();
    end
    for (int i = 0; i < 30; i++) begin i_write = 1'b1; step(); end
    check("pre_rst_cnt", 32'(o_count), 32'd34);
    idle_in();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_valid", 32'(o_valid), 32'd0);
    check("arst_data",  32'(o_data),  32'd0);
    check("arst_count", 32'(o_count), 32'd0);
    check("arst_full",  32'(o_full),  32'd0);
    check("arst_empty", 32'(o_empty), 32'd1);
    check("arst_err",   32'(o_err),   32'd0);
    @(negedge clk); rst_n = 1'b1;
    run_set(1'b0, 2'd2, 30, 1'b1, got);

    // Random traffic including clears, stray starts and wrong-phase beats.
    for (int n = 0; n < 2500; n++) begin
      i_clear     = ($urandom_range(99) < 2);
      i_start     = ($urandom_range(99) < 8);
      i_direction = 1'($urandom);
      i_degrees   = 2'($urandom);
      i_dma_ready = ($urandom_range(99) < 65);
      if ($urandom_range(99) < 90) i_write = (m_state == M_FULL) || (m_state == M_DRAIN);
      else                         i_write = 1'($urandom);
      i_data = PIX_W'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
